inv_round_serial: RTL and testbench

INV_ROUND_SERIAL -- requirements
Module: inv_round_serial

---
 rtl/aes_dec_pkg.sv | 19 +
 rtl/inv_round_serial_if.sv | 25 ++
 rtl/IMix_colrow.sv | 37 +++
 rtl/inv_round_serial.sv | 78 +++++++
 tb/tb_inv_round_serial.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_dec_pkg.sv
// Shared constants, FSM state encoding and GF(2^8) helpers for the inverse-round datapath.
package aes_dec_pkg;

  localparam int STATE_W  = 128;
  localparam int COL_W    = 32;
  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MIX  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Multiply by x modulo x^8 + x^4 + x^3 + x + 1 (0x11B).
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/inv_round_serial_if.sv
// Upstream state/key handshake and downstream result handshake of the serial inverse round.
interface inv_round_serial_if;
  import aes_dec_pkg::*;

  // Each side is a valid/ready pair: a transfer happens on a rising edge where
  // both are high; a source holds its payload stable while valid waits on ready.
  logic               in_valid;
  logic               in_ready;
  logic [0:STATE_W-1] state_in;
  logic [0:STATE_W-1] rkey_in;
  logic               last_round;
  logic               out_valid;
  logic               out_ready;
  logic [0:STATE_W-1] state_out;

  modport master (
    output in_valid, state_in, rkey_in, last_round, out_ready,
    input  in_ready, out_valid, state_out
  );

  modport slave (
    input  in_valid, state_in, rkey_in, last_round, out_ready,
    output in_ready, out_valid, state_out
  );
endinterface

// File: rtl/IMix_colrow.sv
// InvMixColumns on one 32-bit column; byte 0 is the most significant byte.
module IMix_colrow
  import aes_dec_pkg::*;
(
  input  logic [0:COL_W-1] col_in,
  output logic [0:COL_W-1] col_out
);

  logic [7:0] b [4];
  logic [7:0] m9 [4];
  logic [7:0] mb [4];
  logic [7:0] md [4];
  logic [7:0] me [4];

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      logic [7:0] x2;
      logic [7:0] x4;
      logic [7:0] x8;
      b[r]  = col_in[8*r +: 8];
      x2    = xtime(b[r]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[r] = x8 ^ b[r];
      mb[r] = x8 ^ x2 ^ b[r];
      md[r] = x8 ^ x4 ^ b[r];
      me[r] = x8 ^ x4 ^ x2;
    end
  end

  // Rows are {0e,0b,0d,09} rotated right by the row index.
  assign col_out[0:7]   = me[0] ^ mb[1] ^ md[2] ^ m9[3];
  assign col_out[8:15]  = m9[0] ^ me[1] ^ mb[2] ^ md[3];
  assign col_out[16:23] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
  assign col_out[24:31] = mb[0] ^ md[1] ^ m9[2] ^ me[3];

endmodule

// File: rtl/inv_round_serial.sv
// AddRoundKey followed by column-serial InvMixColumns (skipped on the last round).
module inv_round_serial
  import aes_dec_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  inv_round_serial_if.slave   bus,
  output state_t              fsm_state
);

  state_t             fsm;
  logic [1:0]         col;
  logic [0:STATE_W-1] work;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [0:COL_W-1]   mix_in;
  logic [0:COL_W-1]   mix_out;

  assign mix_in = work[{col, 5'b0} +: COL_W];

  IMix_colrow u_imix (
    .col_in  (mix_in),
    .col_out (mix_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm         <= IDLE;
      col         <= 2'd0;
      work        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (bus.in_valid) begin
            work       <= bus.state_in ^ bus.rkey_in;
            col        <= 2'd0;
            in_ready_q <= 1'b0;
            if (bus.last_round) begin
              fsm         <= DONE;
              out_valid_q <= 1'b1;
            end else begin
              fsm <= MIX;
            end
          end
        end
        MIX: begin
          work[{col, 5'b0} +: COL_W] <= mix_out;
          col <= col + 2'd1;
          if (col == 2'd3) begin
            fsm         <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          // Returning through IDLE keeps a transfer and a new accept in separate cycles.
          if (bus.out_ready) begin
            fsm         <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          fsm         <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.state_out = work;
  assign fsm_state     = fsm;

endmodule

// File: tb/tb_inv_round_serial.sv
// Directed bench for inv_round_serial: timeline/result model with per-cycle compare plus literal checks.
module tb_inv_round_serial;
  import aes_dec_pkg::*;

  localparam logic [0:127] S34 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [0:127] R34 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [0:127] K   = 128'h00010203_04050607_08090a0b_0c0d0e0f;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t fsm_state;

  inv_round_serial_if bus ();

  inv_round_serial dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int ready_cyc    = 0;
  int acc_count    = 0;
  int xfer_count   = 0;
  bit started      = 1'b0;

  logic [127:0] exp_q[$];
  logic [127:0] got_q[$];
  int           acc_cyc_q[$];
  int           xfer_cyc_q[$];

  function automatic void chk(string name, logic [127:0] got, logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endfunction

  // Field multiply: carry-less product, then reduce by 0x11B from the top bit down.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (15'(a) << i);
    for (int k = 14; k >= 8; k--)
      if (p[k]) p = p ^ (15'h11b << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] model(input logic [0:127] s, input logic [0:127] k,
                                         input logic last);
    logic [7:0]   coef [4];
    logic [0:127] x;
    logic [0:127] y;
    coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    x = s ^ k;
    if (last) return x;
    y = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        logic [7:0] acc;
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gf_mul(coef[(j - r) & 3], x[32*c + 8*j +: 8]);
        y[32*c + 8*r +: 8] = acc;
      end
    return y;
  endfunction

  // Timeline model: one pair in flight; result due 1 cycle after accept in bypass, 5 with mixing.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else if (exp_q.size() == 0) begin
      if (bus.in_valid === 1'b1) begin
        exp_q.push_back(model(bus.state_in, bus.rkey_in, bus.last_round));
        ready_cyc = cyc + (bus.last_round ? 1 : 5);
        acc_cyc_q.push_back(cyc);
        acc_count++;
      end
    end else if (cyc >= ready_cyc && bus.out_ready === 1'b1) begin
      void'(exp_q.pop_front());
      got_q.push_back(bus.state_out);
      xfer_cyc_q.push_back(cyc);
      xfer_count++;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (started && !rst) begin
      bit exp_rdy;
      bit exp_ov;
      exp_rdy = (exp_q.size() == 0);
      exp_ov  = !exp_rdy && (cyc >= ready_cyc);
      chk("in_ready", 128'(bus.in_ready), 128'(exp_rdy));
      chk("out_valid", 128'(bus.out_valid), 128'(exp_ov));
      if (exp_ov) chk("state_out", bus.state_out, exp_q[0]);
    end
  end

  task automatic wait_acc(input int target);
    int t = 0;
    while (acc_count < target && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (acc_count < target) chk("accept_timeout", 128'(acc_count), 128'(target));
  endtask

  task automatic wait_xfer(input int target);
    int t = 0;
    while (xfer_count < target && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (xfer_count < target) chk("transfer_timeout", 128'(xfer_count), 128'(target));
  endtask

  task automatic send(input logic [0:127] s, input logic [0:127] k, input logic last);
    int n;
    @(negedge clk);
    n = acc_count;
    bus.state_in   = s;
    bus.rkey_in    = k;
    bus.last_round = last;
    bus.in_valid   = 1'b1;
    wait_acc(n + 1);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    int n_acc;
    int n_xfer;
    logic [0:127] hold;
    bus.in_valid   = 1'b0;
    bus.state_in   = '0;
    bus.rkey_in    = '0;
    bus.last_round = 1'b0;
    bus.out_ready  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", 128'(bus.in_ready), 128'(1));
    chk("reset_out_valid", 128'(bus.out_valid), 128'(0));
    chk("reset_state_out", bus.state_out, 128'(0));
    chk("reset_fsm", 128'(fsm_state), 128'(IDLE));
    rst = 1'b0;
    started = 1'b1;

    chk("model_pin_mix", model(S34, '0, 1'b0), R34);
    chk("model_pin_key", model(S34 ^ K, K, 1'b0), R34);
    chk("model_pin_bypass", model('0, K, 1'b1), K);

    // Mix with zero key, then with nonzero key, then bypass.
    bus.out_ready = 1'b1;
    send(S34, '0, 1'b0);
    wait_xfer(1);
    chk("mix_zero_key", got_q[got_q.size()-1], R34);
    chk("mix_zero_key_latency", 128'(xfer_cyc_q[0] - acc_cyc_q[0]), 128'(5));

    send(S34 ^ K, K, 1'b0);
    wait_xfer(2);
    chk("mix_nonzero_key", got_q[got_q.size()-1], R34);

    send('0, K, 1'b1);
    wait_xfer(3);
    chk("bypass", got_q[got_q.size()-1], K);
    chk("bypass_latency", 128'(xfer_cyc_q[2] - acc_cyc_q[2]), 128'(1));

    // Backpressure in DONE with stray in_valid pulses.
    bus.out_ready = 1'b0;
    send(S34 ^ K, K, 1'b0);
    repeat (5) @(negedge clk);
    chk("bp_out_valid", 128'(bus.out_valid), 128'(1));
    hold  = bus.state_out;
    n_acc = acc_count;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid   = (i != 1);
      bus.state_in   = 128'(i + 7);
      bus.rkey_in    = K;
      bus.last_round = 1'b1;
      @(negedge clk);
      chk("bp_stable", bus.state_out, hold);
      chk("bp_in_ready", 128'(bus.in_ready), 128'(0));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_xfer(4);
    chk("bp_result", got_q[got_q.size()-1], R34);
    chk("bp_no_accept", 128'(acc_count), 128'(n_acc));

    // Reset at col=2 aborts the pair.
    send(S34, '0, 1'b0);
    n_xfer = xfer_count;
    repeat (2) @(negedge clk);
    chk("abort_in_mix", 128'(fsm_state), 128'(MIX));
    rst = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", 128'(bus.in_ready), 128'(1));
    chk("abort_out_valid", 128'(bus.out_valid), 128'(0));
    chk("abort_state_out", bus.state_out, 128'(0));
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_no_output", 128'(xfer_count), 128'(n_xfer));

    // Back-to-back with in_valid and out_ready held high.
    n_acc  = acc_count;
    n_xfer = xfer_count;
    @(negedge clk);
    bus.state_in   = S34;
    bus.rkey_in    = '0;
    bus.last_round = 1'b0;
    bus.in_valid   = 1'b1;
    wait_acc(n_acc + 1);
    bus.state_in   = '0;
    bus.rkey_in    = K;
    bus.last_round = 1'b1;
    wait_acc(n_acc + 2);
    bus.in_valid = 1'b0;
    wait_xfer(n_xfer + 2);
    chk("b2b_first", got_q[got_q.size()-2], R34);
    chk("b2b_second", got_q[got_q.size()-1], K);
    chk("b2b_gap", 128'(acc_cyc_q[acc_cyc_q.size()-1] - xfer_cyc_q[xfer_cyc_q.size()-2]), 128'(1));

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got=%0d expected=0", 1);
    $fatal(1, "timeout");
  end

endmodule
